// File: rtl/ysyx_220053_dmem_resp.sv
// Data-memory responder: one request at a time, fixed LAT-cycle latency, byte-lane steered
// 64-bit backing store with right-justified, zero-filled load data.
module ysyx_220053_dmem_resp #(
  parameter int          ADDR_W = 16,
  parameter logic [63:0] BASE   = 64'h8000_0000,
  parameter int          LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int         IDX_W    = ADDR_W - 3;
  localparam int         DEPTH    = 1 << IDX_W;
  localparam logic [2:0] CNT_INIT = 3'(LAT - 1);
  localparam bit         LAT_ONE  = (LAT == 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [63:0] addr_reg, wdata_reg;
  logic [1:0]  size_reg;
  logic        wen_reg;
  logic [63:0] rsp_rdata_reg;
  logic        rsp_err_reg;

  logic        accept, commit;
  logic [63:0] cur_addr, cur_wdata, off;
  logic [1:0]  cur_size;
  logic        cur_wen;
  logic [63:0] size_mask;
  logic [7:0]  byte_mask, strobe;
  logic        misaligned, out_of_win, err, wr_en;
  logic [2:0]  lane;
  logic [IDX_W-1:0] idx;
  logic [63:0] wdata_sh, rd_word, rd_data;

  assign accept = req_valid & (state_reg == IDLE);
  // With LAT = 1 the commit happens on the accept edge itself, so the live request is used.
  assign commit = (accept & LAT_ONE) | ((state_reg == WAIT) && (cnt_reg == 3'd0));

  assign cur_addr  = (state_reg == IDLE) ? req_addr  : addr_reg;
  assign cur_wdata = (state_reg == IDLE) ? req_wdata : wdata_reg;
  assign cur_size  = (state_reg == IDLE) ? req_size  : size_reg;
  assign cur_wen   = (state_reg == IDLE) ? req_wen   : wen_reg;

  assign off        = cur_addr - BASE;
  assign lane       = off[2:0];
  assign idx        = off[ADDR_W-1:3];
  assign out_of_win = |off[63:ADDR_W];

  always_comb begin
    size_mask  = 64'hFF;
    byte_mask  = 8'h01;
    misaligned = 1'b0;
    case (cur_size)
      2'd0: begin
        size_mask = 64'hFF;
        byte_mask = 8'h01;
      end
      2'd1: begin
        size_mask  = 64'hFFFF;
        byte_mask  = 8'h03;
        misaligned = cur_addr[0];
      end
      2'd2: begin
        size_mask  = 64'hFFFF_FFFF;
        byte_mask  = 8'h0F;
        misaligned = |cur_addr[1:0];
      end
      default: begin
        size_mask  = '1;
        byte_mask  = 8'hFF;
        misaligned = |cur_addr[2:0];
      end
    endcase
  end

  assign err      = out_of_win | misaligned;
  assign wr_en    = commit & cur_wen & ~err;
  assign wdata_sh = (cur_wdata & size_mask) << {lane, 3'b000};
  assign strobe   = byte_mask << lane;
  assign rd_data  = (rd_word >> {lane, 3'b000}) & size_mask;

  // One independent byte array per lane keeps the partial writes single-driver.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      always_ff @(posedge clk) begin
        if (wr_en && strobe[gi]) begin
          mem_lane[idx] <= wdata_sh[8*gi +: 8];
        end
      end
      assign rd_word[8*gi +: 8] = mem_lane[idx];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          cnt_next = CNT_INIT;
          if (LAT_ONE) state_next = RESP;
          else         state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt_reg == 3'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 3'd1;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      size_reg      <= '0;
      wen_reg       <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        size_reg  <= req_size;
        wen_reg   <= req_wen;
      end
      if (commit) begin
        rsp_err_reg   <= err;
        rsp_rdata_reg <= (err || cur_wen) ? 64'd0 : rd_data;
      end
    end
  end

  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_ysyx_220053_dmem_resp.sv
// Directed bench: vector table on a LAT=2 responder plus hand sequences for back-pressure,
// mid-access reset and a LAT=1 build.
module tb_ysyx_220053_dmem_resp;

  typedef struct {
    logic        wen;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  logic        clk, rst;
  logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [63:0] req_addr, req_wdata, rsp_rdata;
  logic [1:0]  req_size;

  logic        req_valid_1, req_ready_1, req_wen_1, rsp_valid_1, rsp_ready_1, rsp_err_1;
  logic [63:0] req_addr_1, req_wdata_1, rsp_rdata_1;
  logic [1:0]  req_size_1;

  int checks = 0;
  int errors = 0;
  int k;
  vec_t vecs [20];
  vec_t ops1 [5];

  ysyx_220053_dmem_resp #(.ADDR_W(16), .BASE(64'h8000_0000), .LAT(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  ysyx_220053_dmem_resp #(.ADDR_W(16), .BASE(64'h8000_0000), .LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_1), .req_ready(req_ready_1), .req_wen(req_wen_1),
    .req_addr(req_addr_1), .req_size(req_size_1), .req_wdata(req_wdata_1),
    .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1), .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                              input logic [63:0] wdata, input logic [63:0] exp_rdata,
                              input logic exp_err);
    vec_t v;
    v.wen = wen; v.addr = addr; v.size = size; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Called right after the accept edge; counts edges until rsp_valid is seen (bounded).
  task automatic wait_rsp(output int n);
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    chk("req_ready_idle", idx, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr;
    req_size = v.size; req_wdata = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(n);
    chk("latency", idx, 64'(n), 64'd2);
    chk("rdata", idx, rsp_rdata, v.exp_rdata);
    chk("err", idx, 64'(rsp_err), 64'(v.exp_err));
    $display("txn %0d: wen=%0d addr=%h size=%0d wdata=%h rdata=%h err=%0d lat=%0d",
             idx, v.wen, v.addr, v.size, v.wdata, rsp_rdata, rsp_err, n);
    @(posedge clk);
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 64'h8000_0000, 2'd3, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
    vecs[1]  = mk(1'b1, 64'h8000_0008, 2'd3, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
    vecs[2]  = mk(1'b0, 64'h8000_0008, 2'd3, 64'h0, 64'h1122_3344_5566_7788, 1'b0);
    vecs[3]  = mk(1'b1, 64'h8000_000B, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 1'b0);
    vecs[4]  = mk(1'b0, 64'h8000_0008, 2'd3, 64'h0, 64'h1122_3344_AB66_7788, 1'b0);
    vecs[5]  = mk(1'b0, 64'h8000_000A, 2'd1, 64'h0, 64'h0000_0000_0000_AB66, 1'b0);
    vecs[6]  = mk(1'b0, 64'h8000_0006, 2'd2, 64'h0, 64'h0, 1'b1);
    vecs[7]  = mk(1'b1, 64'h8001_0000, 2'd3, 64'hCAFE_BABE_CAFE_BABE, 64'h0, 1'b1);
    vecs[8]  = mk(1'b0, 64'h8000_0008, 2'd3, 64'h0, 64'h1122_3344_AB66_7788, 1'b0);
    vecs[9]  = mk(1'b0, 64'h8000_0000, 2'd3, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b0);
    vecs[10] = mk(1'b0, 64'h8000_000F, 2'd0, 64'h0, 64'h11, 1'b0);
    vecs[11] = mk(1'b0, 64'h8000_000C, 2'd2, 64'h0, 64'h1122_3344, 1'b0);
    vecs[12] = mk(1'b1, 64'h8000_0010, 2'd3, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 1'b0);
    vecs[13] = mk(1'b1, 64'h8000_0012, 2'd1, 64'h1234_BEEF, 64'h0, 1'b0);
    vecs[14] = mk(1'b0, 64'h8000_0010, 2'd3, 64'h0, 64'hA5A5_A5A5_BEEF_A5A5, 1'b0);
    vecs[15] = mk(1'b0, 64'h8000_0001, 2'd1, 64'h0, 64'h0, 1'b1);
    vecs[16] = mk(1'b0, 64'h7FFF_FFF8, 2'd3, 64'h0, 64'h0, 1'b1);
    vecs[17] = mk(1'b1, 64'h8000_FFFF, 2'd0, 64'h5A, 64'h0, 1'b0);
    vecs[18] = mk(1'b0, 64'h8000_FFFF, 2'd0, 64'h0, 64'h5A, 1'b0);
    vecs[19] = mk(1'b0, 64'h8000_0004, 2'd2, 64'h0, 64'h0123_4567, 1'b0);

    ops1[0] = mk(1'b1, 64'h8000_0000, 2'd3, 64'hAAAA_5555_AAAA_5555, 64'h0, 1'b0);
    ops1[1] = mk(1'b0, 64'h8000_0000, 2'd3, 64'h0, 64'hAAAA_5555_AAAA_5555, 1'b0);
    ops1[2] = mk(1'b1, 64'h8000_0104, 2'd2, 64'h0BAD_F00D, 64'h0, 1'b0);
    ops1[3] = mk(1'b0, 64'h8000_0106, 2'd1, 64'h0, 64'h0BAD, 1'b0);
    ops1[4] = mk(1'b0, 64'h8000_0104, 2'd2, 64'h0, 64'h0BAD_F00D, 1'b0);

    rst = 1'b0;
    req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    req_valid_1 = 1'b0; req_wen_1 = 1'b0; req_addr_1 = '0; req_size_1 = '0; req_wdata_1 = '0;
    rsp_ready_1 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 0, 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 0, 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 0, rsp_rdata, 64'd0);
    chk("rst_rsp_err", 0, 64'(rsp_err), 64'd0);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) run_vec(vecs[i], i);

    // Back-pressure: response held 5 cycles while a different request waits on the port.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h8000_0008; req_size = 2'd3; req_wdata = '0;
    @(posedge clk);
    #1 req_addr = 64'h8000_0000;
    wait_rsp(k);
    chk("bp_latency", 0, 64'(k), 64'd2);
    for (int c = 0; c < 5; c++) begin
      chk("bp_rsp_valid", c, 64'(rsp_valid), 64'd1);
      chk("bp_rdata", c, rsp_rdata, 64'h1122_3344_AB66_7788);
      chk("bp_err", c, 64'(rsp_err), 64'd0);
      chk("bp_req_ready", c, 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    $display("txn bp: held load addr=80000008 rdata=%h err=%0d", rsp_rdata, rsp_err);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_after_req_ready", 0, 64'(req_ready), 64'd1);
    chk("bp_after_rsp_valid", 0, 64'(rsp_valid), 64'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(k);
    chk("bp2_latency", 0, 64'(k), 64'd2);
    chk("bp2_rdata", 0, rsp_rdata, 64'h0123_4567_89AB_CDEF);
    $display("txn bp2: load addr=80000000 rdata=%h err=%0d lat=%0d", rsp_rdata, rsp_err, k);
    @(posedge clk);

    // Reset during WAIT: the store must be abandoned.
    @(negedge clk);
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0010; req_size = 2'd2;
    req_wdata = 64'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_req_ready_in", 0, 64'(req_ready), 64'd1);
    chk("rstw_rsp_valid_in", 0, 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstw_req_ready", 0, 64'(req_ready), 64'd1);
    chk("rstw_rsp_valid", 0, 64'(rsp_valid), 64'd0);
    chk("rstw_rsp_rdata", 0, rsp_rdata, 64'd0);
    chk("rstw_rsp_err", 0, 64'(rsp_err), 64'd0);
    $display("txn rst_wait: store addr=80000010 data=deadbeef abandoned");
    run_vec(mk(1'b0, 64'h8000_0010, 2'd2, 64'h0, 64'hBEEF_A5A5, 1'b0), 100);

    // Reset during RESP: the committed store stays, the response is dropped.
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h8000_0014; req_size = 2'd2;
    req_wdata = 64'h1357_9BDF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_rsp(k);
    chk("rstr_rsp_valid", 0, 64'(rsp_valid), 64'd1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("rstr_rsp_valid_after", 0, 64'(rsp_valid), 64'd0);
    chk("rstr_req_ready_after", 0, 64'(req_ready), 64'd1);
    $display("txn rst_resp: store addr=80000014 data=13579bdf response dropped");
    run_vec(mk(1'b0, 64'h8000_0010, 2'd3, 64'h0, 64'h1357_9BDF_BEEF_A5A5, 1'b0), 101);

    // LAT = 1 build: request held valid continuously, accepts every second edge.
    @(negedge clk);
    rsp_ready_1 = 1'b1;
    req_valid_1 = 1'b1; req_wen_1 = ops1[0].wen; req_addr_1 = ops1[0].addr;
    req_size_1 = ops1[0].size; req_wdata_1 = ops1[0].wdata;
    chk("l1_req_ready_first", 0, 64'(req_ready_1), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("l1_rsp_valid", i, 64'(rsp_valid_1), 64'd1);
      chk("l1_req_ready_busy", i, 64'(req_ready_1), 64'd0);
      chk("l1_rdata", i, rsp_rdata_1, ops1[i].exp_rdata);
      chk("l1_err", i, 64'(rsp_err_1), 64'(ops1[i].exp_err));
      $display("txn l1 %0d: wen=%0d addr=%h size=%0d rdata=%h err=%0d",
               i, ops1[i].wen, ops1[i].addr, ops1[i].size, rsp_rdata_1, rsp_err_1);
      if (i < 4) begin
        req_wen_1 = ops1[i+1].wen; req_addr_1 = ops1[i+1].addr;
        req_size_1 = ops1[i+1].size; req_wdata_1 = ops1[i+1].wdata;
      end else begin
        req_valid_1 = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      chk("l1_rsp_valid_low", i, 64'(rsp_valid_1), 64'd0);
      chk("l1_req_ready_idle", i, 64'(req_ready_1), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
